// File: rtl/wsg_sound_if.sv
// Bus bundle for the Namco WSG: CPU register-write port, wave-PROM read port
// and the mixed audio sample handed to the HDMI audio path.
interface wsg_sound_if;
  logic              reg_we;
  logic [4:0]        reg_addr;
  logic [3:0]        reg_din;
  logic              rom_rd;
  logic [8:0]        rom_addr;
  logic [3:0]        rom_data;
  logic signed [9:0] sample;
  logic              sample_valid;

  // System side: CPU bus, PROM and audio sink.
  modport master (
    output reg_we, reg_addr, reg_din, rom_data,
    input  rom_rd, rom_addr, sample, sample_valid
  );

  // Sound generator side.
  modport slave (
    input  reg_we, reg_addr, reg_din, rom_data,
    output rom_rd, rom_addr, sample, sample_valid
  );
endinterface

// File: rtl/wsg_sound.sv
// Namco 3-voice waveform sound generator: three voices share one wave-PROM port and
// are mixed into one signed 10-bit sample per frame. Optional IIR output filter: WSG_LOWPASS_EN.
module wsg_sound #(
  parameter int CLK_HZ  = 47828000,
  parameter int SLOT_HZ = 72000
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  wsg_sound_if.slave bus
);

  localparam int DIV   = CLK_HZ / SLOT_HZ;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_CAPT = CNT_W'(HALF + 1);

  localparam logic [1:0] VOICE_0 = 2'd0;
  localparam logic [1:0] VOICE_1 = 2'd1;
  localparam logic [1:0] VOICE_2 = 2'd2;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        voice_q, voice_d;
  logic [3:0]        regs_q [32];
  logic [3:0]        regs_d [32];
  logic [19:0]       acc_q [3];
  logic [19:0]       acc_d [3];
  logic [3:0]        d_q, d_d;
  logic signed [9:0] sum_q, sum_d;
  logic signed [9:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              rom_rd_q, rom_rd_d;
  logic [8:0]        rom_addr_q, rom_addr_d;

  logic [4:0]        base;
  logic [3:0]        wave_cur, vol_cur;
  logic [19:0]       freq_cur, acc_cur;
  logic              slot_end, frame_end;
  logic signed [9:0] vol_x, d_x, term, frame_x, filt_out;

  // Register block of the voice owning the current slot starts at offset 5*voice.
  always_comb begin
    case (voice_q)
      VOICE_1: begin base = 5'd5;  acc_cur = acc_q[1]; end
      VOICE_2: begin base = 5'd10; acc_cur = acc_q[2]; end
      default: begin base = 5'd0;  acc_cur = acc_q[0]; end
    endcase
    wave_cur = regs_q[5'h05 + base];
    vol_cur  = regs_q[5'h15 + base];
    freq_cur = {regs_q[5'h14 + base], regs_q[5'h13 + base], regs_q[5'h12 + base],
                regs_q[5'h11 + base], (voice_q == VOICE_0) ? regs_q[5'h10] : 4'h0};
  end

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (voice_q == VOICE_2);

  // Wave samples are offset-binary around 7, so a silent wave contributes -7*volume.
  assign vol_x   = {6'b0, vol_cur};
  assign d_x     = {6'b0, d_q} - 10'd7;
  assign term    = vol_x * d_x;
  assign frame_x = sum_q + term;

`ifdef WSG_LOWPASS_EN
  logic signed [11:0] y_q, y_d, y_diff;

  always_comb begin
    y_diff = {{2{frame_x[9]}}, frame_x} - y_q;
    y_d    = y_q;
    if (frame_end) begin
      y_d = y_q + (y_diff >>> 2);
    end
    if (y_d > 12'sd511) begin
      filt_out = 10'sd511;
    end else if (y_d < -12'sd512) begin
      filt_out = -10'sd512;
    end else begin
      filt_out = y_d[9:0];
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end
`else
  assign filt_out = frame_x;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    cnt_d          = slot_end ? '0 : cnt_q + 1'b1;
    voice_d        = voice_q;
    regs_d         = regs_q;
    d_d            = d_q;
    sum_d          = sum_q;
    sample_d       = sample_q;
    sample_valid_d = frame_end;
    rom_rd_d       = (cnt_q == CNT_PRE);
    rom_addr_d     = rom_addr_q;

    if (slot_end) begin
      voice_d = (voice_q == VOICE_2) ? VOICE_0 : voice_q + 2'd1;
    end

    if (bus.reg_we) begin
      regs_d[bus.reg_addr] = bus.reg_din;
    end

    // Index comes from acc[17:13]: each voice only advances once per 24 kHz frame.
    if (rom_rd_d) begin
      rom_addr_d = {wave_cur, acc_cur[17:13]};
    end

    if (cnt_q == CNT_CAPT) begin
      d_d = bus.rom_data;
    end

    for (int v = 0; v < 3; v++) begin
      acc_d[v] = acc_q[v];
      if (slot_end && (voice_q == 2'(v))) begin
        acc_d[v] = acc_cur + freq_cur;
      end
    end

    if (slot_end) begin
      case (voice_q)
        VOICE_0: sum_d = term;
        VOICE_1: sum_d = sum_q + term;
        default: begin
          sum_d    = '0;
          sample_d = filt_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      voice_q        <= VOICE_0;
      d_q            <= '0;
      sum_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      rom_rd_q       <= 1'b0;
      rom_addr_q     <= '0;
      // NOTE: the register file is flop-based and must read as zero after reset, so it is cleared here rather than left to a RAM.
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 4'h0;
      end
      for (int v = 0; v < 3; v++) begin
        acc_q[v] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      cnt_q          <= cnt_d;
      voice_q        <= voice_d;
      regs_q         <= regs_d;
      acc_q          <= acc_d;
      d_q            <= d_d;
      sum_q          <= sum_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      rom_rd_q       <= rom_rd_d;
      rom_addr_q     <= rom_addr_d;
    end
  end

  assign bus.rom_rd       = rom_rd_q;
  assign bus.rom_addr     = rom_addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = sample_valid_q;

endmodule

// File: tb/tb_wsg_sound.sv
// Bench for wsg_sound: a time-indexed behavioural model checked every cycle,
// plus directed frames with hand-computed sample values.
module tb_wsg_sound;

  localparam int CLK_HZ  = 936000;
  localparam int SLOT_HZ = 72000;
  localparam int DIV     = CLK_HZ / SLOT_HZ;
  localparam int S       = DIV + 1;
  localparam int HALF    = DIV / 2;
  localparam int F       = 3 * S;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;

  wsg_sound_if bus ();

  wsg_sound #(.CLK_HZ(CLK_HZ), .SLOT_HZ(SLOT_HZ)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
  endtask

  // PROM contents and responder: data follows a read strobe by one cycle, garbage otherwise.
  logic [3:0] rom_table [512];
  logic       rd_seen = 1'b0;
  logic [8:0] addr_seen = '0;

  initial forever begin
    @(negedge clk_pixel);
    rd_seen   = bus.rom_rd;
    addr_seen = bus.rom_addr;
  end

  initial forever begin
    @(posedge clk_pixel);
    #1;
    bus.rom_data = rd_seen ? rom_table[addr_seen] : 4'($urandom);
  end

  // Behavioural model: position in time decides slot and voice; outputs are what the next cycle must show.
  int         m_t;
  logic [3:0] m_regs [32];
  int         m_acc [3];
  int         m_d [3];
  int         m_fsum, m_y;
  int         m_rd, m_addr, m_valid, m_sample;

  function automatic int freq_of(input int v);
    int o = 5 * v;
    int f = m_regs[16'h14 + o] * 65536 + m_regs[16'h13 + o] * 4096 +
            m_regs[16'h12 + o] * 256 + m_regs[16'h11 + o] * 16;
    if (v == 0) f += m_regs[16'h10];
    return f;
  endfunction

  task automatic m_reset();
    m_t = 0; m_fsum = 0; m_y = 0;
    m_rd = 0; m_addr = 0; m_valid = 0; m_sample = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 4'h0;
    for (int v = 0; v < 3; v++) begin m_acc[v] = 0; m_d[v] = 0; end
  endtask

  task automatic m_step();
    int ph = m_t % S;
    int v  = (m_t / S) % 3;
    int t1 = m_t + 1;
    int v1 = (t1 / S) % 3;
    int vol, term;
    if (ph == HALF) m_d[v] = rom_table[m_addr];
    m_valid = 0;
    if (ph == DIV) begin
      vol      = m_regs[16'h15 + 5 * v];
      term     = vol * (m_d[v] - 7);
      m_acc[v] = (m_acc[v] + freq_of(v)) % (1 << 20);
      m_fsum   = (v == 0) ? term : m_fsum + term;
      if (v == 2) begin
`ifdef WSG_LOWPASS_EN
        m_y      = m_y + ((m_fsum - m_y) >>> 2);
        m_sample = (m_y > 511) ? 511 : (m_y < -512) ? -512 : m_y;
`else
        m_sample = m_fsum;
`endif
        m_valid = 1;
      end
    end
    if (t1 % S == HALF) begin
      m_rd   = 1;
      m_addr = m_regs[5 + 5 * v1] * 32 + ((m_acc[v1] >> 13) % 32);
    end else begin
      m_rd = 0;
    end
    if (bus.reg_we) m_regs[bus.reg_addr] = bus.reg_din;
    m_t = t1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk_pixel);
      if (!reset_n) begin
        m_reset();
        check("reset_sample", bus.sample, 0);
        check("reset_valid", bus.sample_valid, 0);
        check("reset_rom_rd", bus.rom_rd, 0);
      end else begin
        check("rom_rd", bus.rom_rd, m_rd);
        check("rom_addr", bus.rom_addr, m_addr);
        check("sample_valid", bus.sample_valid, m_valid);
        check("sample", bus.sample, m_sample);
        m_step();
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(posedge clk_pixel); #1;
    bus.reg_we = 1'b1; bus.reg_addr = 5'(a); bus.reg_din = 4'(d);
    @(posedge clk_pixel); #1;
    bus.reg_we = 1'b0;
  endtask

  task automatic set_table(input int val);
    @(posedge clk_pixel); #2;
    for (int i = 0; i < 512; i++) rom_table[i] = (val < 0) ? 4'($urandom) : 4'(val);
  endtask

  task automatic wait_valid(output int n, output int s);
    n = 0; s = 0;
    repeat (2 * F) begin
      @(negedge clk_pixel);
      if (bus.sample_valid === 1'b1) begin
        s = int'(bus.sample);
        return;
      end
      n++;
    end
    timeout("wait_valid");
  endtask

  task automatic voice0_index(output int idx);
    idx = -1;
    repeat (2 * F) begin
      @(posedge clk_pixel); #1;
      if (m_t % F == HALF) begin
        idx = int'(bus.rom_addr[4:0]);
        return;
      end
    end
    timeout("voice0_read");
  endtask

  task automatic rd_period(output int n);
    bit found = 0;
    n = 0;
    repeat (2 * S) begin
      @(negedge clk_pixel);
      if (bus.rom_rd === 1'b1) begin found = 1; break; end
    end
    if (!found) begin timeout("rom_rd_first"); return; end
    repeat (2 * S) begin
      @(negedge clk_pixel);
      n++;
      if (bus.rom_rd === 1'b1) return;
    end
    timeout("rom_rd_next");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, idx, prev, base;
    bit wrap;
    int exp_seq [4];

    bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_din = '0; bus.rom_data = '0;
    for (int i = 0; i < 512; i++) rom_table[i] = 4'($urandom);

    // Reset state and idle cadence.
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("init_sample", bus.sample, 0);
    check("init_rom_addr", bus.rom_addr, 0);
    @(posedge clk_pixel); #1 reset_n = 1'b1;
    wait_valid(n, s);
    check("first_valid_latency", n, F);
    check("idle_sample", s, 0);
    wait_valid(n, s);
    check("valid_period", n + 1, F);
    check("idle_sample2", s, 0);
    rd_period(n);
    check("rom_rd_period", n, S);

    // One loud voice, PROM stuck at 15: 15*(15-7) = 120.
    wr(16'h05, 0); wr(16'h15, 15);
    set_table(15);
    wait_valid(n, s); wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("one_voice_120", s, 120);
`endif

    // All three voices at full volume: 3*15*(-7) = -315, 3*15*8 = 360.
    wr(16'h1A, 15); wr(16'h1F, 15);
    set_table(0);
    wait_valid(n, s); wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("three_voice_min", s, -315);
`endif
    set_table(15);
    wait_valid(n, s); wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("three_voice_max", s, 360);
`endif

    // freq = 0x02000 (reg 0x13 = 2): voice-0 wave index advances one step per frame.
    wr(16'h1A, 0); wr(16'h1F, 0); wr(16'h13, 2);
    voice0_index(prev);
    wrap = 0;
    for (int k = 0; k < 33; k++) begin
      voice0_index(idx);
      check("idx_step", idx, (prev + 1) % 32);
      if (prev == 31 && idx == 0) wrap = 1;
      prev = idx;
    end
    check("idx_wrap", wrap, 1);

    // freq = 0x00001: index holds well inside 8192 frames.
    wr(16'h13, 0); wr(16'h10, 1);
    voice0_index(idx); voice0_index(base);
    for (int k = 0; k < 40; k++) begin
      voice0_index(idx);
      check("idx_hold", idx, base);
    end

    // Volume written in the slot-end cycle of voice 0: old volume this frame, silence next.
    wr(16'h10, 0); wr(16'h15, 15);
    wait_valid(n, s); wait_valid(n, s);
    n = 0;
    do begin
      @(posedge clk_pixel); #1;
      n++;
    end while (m_t % F != S - 1 && n < 2 * F);
    bus.reg_we = 1'b1; bus.reg_addr = 5'h15; bus.reg_din = 4'h0;
    @(posedge clk_pixel); #1 bus.reg_we = 1'b0;
    wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("vol_same_cycle_old", s, 120);
`endif
    wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("vol_same_cycle_new", s, 0);
`endif

    // Mid-frame reset, then a 0 -> 120 step from a clean state.
    wr(16'h15, 15);
    wait_valid(n, s); wait_valid(n, s);
`ifndef WSG_LOWPASS_EN
    check("pre_reset_sample", s, 120);
`endif
    repeat (5) @(posedge clk_pixel);
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_sample", bus.sample, 0);
    check("async_reset_valid", bus.sample_valid, 0);
    check("async_reset_rom_addr", bus.rom_addr, 0);
    repeat (2) @(posedge clk_pixel);
    #1 reset_n = 1'b1;
    wr(16'h15, 15);
`ifdef WSG_LOWPASS_EN
    exp_seq = '{30, 52, 69, 81};
`else
    exp_seq = '{120, 120, 120, 120};
`endif
    for (int k = 0; k < 4; k++) begin
      wait_valid(n, s);
      check("step_response", s, exp_seq[k]);
    end
`ifdef WSG_LOWPASS_EN
    repeat (20) wait_valid(n, s);
    check("lowpass_settled", s, 117);
`endif

    // Random register traffic and PROM contents against the model.
    @(posedge clk_pixel); #1 reset_n = 1'b0;
    @(posedge clk_pixel); #1 reset_n = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk_pixel); #1;
      if ($urandom_range(0, 3) == 0) begin
        bus.reg_we   = 1'b1;
        bus.reg_addr = 5'($urandom_range(0, 31));
        bus.reg_din  = 4'($urandom);
      end else begin
        bus.reg_we = 1'b0;
      end
      if (i % 500 == 0) begin
        #1;
        for (int j = 0; j < 512; j++) rom_table[j] = 4'($urandom);
      end
    end
    @(posedge clk_pixel); #1 bus.reg_we = 1'b0;
    repeat (2 * F) @(posedge clk_pixel);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
